// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: active-low codes (bit 7 = a .. bit 1 = g, bit 0 = dp)
// and the scan FSM state type used by the display-bus reader.
package seg_pkg;

    localparam int SEG_A_BIT  = 7;
    localparam int SEG_B_BIT  = 6;
    localparam int SEG_C_BIT  = 5;
    localparam int SEG_D_BIT  = 4;
    localparam int SEG_E_BIT  = 3;
    localparam int SEG_F_BIT  = 2;
    localparam int SEG_G_BIT  = 1;
    localparam int SEG_DP_BIT = 0;

    // Codes carry dp unlit (bit 0 = 1); 0 = segment lit.
    localparam logic [7:0] SEG_0     = 8'h03;
    localparam logic [7:0] SEG_1     = 8'h9F;
    localparam logic [7:0] SEG_2     = 8'h25;
    localparam logic [7:0] SEG_3     = 8'h0D;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h49;
    localparam logic [7:0] SEG_6     = 8'h41;
    localparam logic [7:0] SEG_7     = 8'h1F;
    localparam logic [7:0] SEG_8     = 8'h01;
    localparam logic [7:0] SEG_9     = 8'h09;
    localparam logic [7:0] SEG_A     = 8'h11;
    localparam logic [7:0] SEG_B     = 8'hC1;
    localparam logic [7:0] SEG_C     = 8'h63;
    localparam logic [7:0] SEG_D     = 8'h85;
    localparam logic [7:0] SEG_E     = 8'h61;
    localparam logic [7:0] SEG_F     = 8'h71;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        HOLD
    } scan_state_t;

endpackage

// File: rtl/seg_code_decode.sv
// Combinational decode of one active-low segment pattern back to a hex nibble,
// with blank/invalid classification; dp is reported independently of the match.
module seg_code_decode
    import seg_pkg::*;
(
    input  logic [7:0] seg,
    output logic [3:0] hex,
    output logic       dp,
    output logic       blank,
    output logic       invalid
);

    logic       match;
    logic [7:0] body;

    assign body = {seg[SEG_A_BIT:SEG_G_BIT], 1'b1};

    always_comb begin
        hex   = '0;
        match = 1'b1;
        case (body)
            SEG_0:   hex = 4'h0;
            SEG_1:   hex = 4'h1;
            SEG_2:   hex = 4'h2;
            SEG_3:   hex = 4'h3;
            SEG_4:   hex = 4'h4;
            SEG_5:   hex = 4'h5;
            SEG_6:   hex = 4'h6;
            SEG_7:   hex = 4'h7;
            SEG_8:   hex = 4'h8;
            SEG_9:   hex = 4'h9;
            SEG_A:   hex = 4'hA;
            SEG_B:   hex = 4'hB;
            SEG_C:   hex = 4'hC;
            SEG_D:   hex = 4'hD;
            SEG_E:   hex = 4'hE;
            SEG_F:   hex = 4'hF;
            default: match = 1'b0;
        endcase
    end

    assign blank   = (body == SEG_BLANK);
    assign invalid = !match && !blank;
    assign dp      = ~seg[SEG_DP_BIT];

endmodule

// File: rtl/seg_scan_decoder.sv
// Reader for a multiplexed common-anode 7-seg bus: synchronises the lines, samples each
// digit once per scan visit, debounces per digit and publishes stable frames over valid/ready.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 2,
    parameter int SETTLE_CYC = 4,
    parameter int STABLE_CNT = 3,
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_en,
    output logic [4*NUM_DIGITS-1:0] dout,
    output logic [NUM_DIGITS-1:0]   dp_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    err,
    output logic [DW-1:0]           err_digit
);

    localparam int FW = 5 * NUM_DIGITS;

    logic [7:0]            seg_s1, seg_s2;
    logic [NUM_DIGITS-1:0] dig_s1, dig_s2;

    scan_state_t           state, state_nxt;
    logic [3:0]            cnt, cnt_nxt;
    logic [NUM_DIGITS-1:0] cur_en;
    logic [DW-1:0]         cur_idx, hot_idx;
    logic                  latch_cur, do_sample;

    logic [3:0]            dec_hex;
    logic                  dec_dp, dec_blank, dec_invalid;

    logic [3:0]            cand_hex [NUM_DIGITS];
    logic                  cand_dp  [NUM_DIGITS];
    logic [2:0]            stab     [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] committed;
    logic                  cur_eq;
    logic [2:0]            stab_inc;

    logic [FW-1:0]         frame, last_pub, shadow;
    logic                  pub_any, pending, pub_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1 <= '0;
            seg_s2 <= '0;
            dig_s1 <= '0;
            dig_s2 <= '0;
        end else begin
            seg_s1 <= seg_in;
            seg_s2 <= seg_s1;
            dig_s1 <= dig_en;
            dig_s2 <= dig_s1;
        end
    end

    always_comb begin
        hot_idx = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++)
            if (dig_s2[i]) hot_idx = DW'(i);
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        latch_cur = 1'b0;
        do_sample = 1'b0;
        case (state)
            IDLE: begin
                if ($onehot(dig_s2)) begin
                    state_nxt = SETTLE;
                    cnt_nxt   = '0;
                    latch_cur = 1'b1;
                end
            end
            SETTLE: begin
                if (dig_s2 != cur_en)
                    state_nxt = IDLE;
                else if (cnt == 4'(SETTLE_CYC - 1))
                    state_nxt = SAMPLE;
                else
                    cnt_nxt = cnt + 4'd1;
            end
            SAMPLE: begin
                do_sample = 1'b1;
                state_nxt = HOLD;
            end
            HOLD: begin
                if (dig_s2 != cur_en) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            cur_en  <= '0;
            cur_idx <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (latch_cur) begin
                cur_en  <= dig_s2;
                cur_idx <= hot_idx;
            end
        end
    end

    seg_code_decode u_dec (
        .seg     (seg_s2),
        .hex     (dec_hex),
        .dp      (dec_dp),
        .blank   (dec_blank),
        .invalid (dec_invalid)
    );

    // Candidate identity includes dp so a dp-only change restarts debounce.
    assign cur_eq   = ({dec_hex, dec_dp} == {cand_hex[cur_idx], cand_dp[cur_idx]});
    assign stab_inc = (stab[cur_idx] < 3'(STABLE_CNT)) ? stab[cur_idx] + 3'd1 : stab[cur_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_hex  <= '{default: '0};
            cand_dp   <= '{default: 1'b0};
            stab      <= '{default: '0};
            committed <= '0;
            err       <= 1'b0;
            err_digit <= '0;
        end else begin
            err <= do_sample && dec_invalid;
            if (do_sample && dec_invalid) err_digit <= cur_idx;
            if (do_sample) begin
                if (dec_blank || dec_invalid) begin
                    stab[cur_idx]      <= '0;
                    committed[cur_idx] <= 1'b0;
                end else if (cur_eq) begin
                    stab[cur_idx] <= stab_inc;
                    if (stab_inc == 3'(STABLE_CNT)) committed[cur_idx] <= 1'b1;
                end else begin
                    cand_hex[cur_idx]  <= dec_hex;
                    cand_dp[cur_idx]   <= dec_dp;
                    stab[cur_idx]      <= 3'd1;
                    committed[cur_idx] <= (STABLE_CNT == 1);
                end
            end
        end
    end

    always_comb begin
        frame = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            frame[4*i +: 4]            = cand_hex[i];
            frame[4*NUM_DIGITS + i]    = cand_dp[i];
        end
    end

    assign pub_req = (&committed) && (!pub_any || (frame != last_pub));

    // A fresh frame supersedes any pending shadow; the shadow only reloads after a low cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout      <= '0;
            dp_out    <= '0;
            out_valid <= 1'b0;
            last_pub  <= '0;
            shadow    <= '0;
            pub_any   <= 1'b0;
            pending   <= 1'b0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (pub_req) begin
                last_pub <= frame;
                pub_any  <= 1'b1;
                if (!out_valid) begin
                    {dp_out, dout} <= frame;
                    out_valid      <= 1'b1;
                    pending        <= 1'b0;
                end else begin
                    shadow  <= frame;
                    pending <= 1'b1;
                end
            end else if (!out_valid && pending) begin
                {dp_out, dout} <= shadow;
                out_valid      <= 1'b1;
                pending        <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: scans two digits with hand-picked segment codes
// and checks published frames, error pulses, backpressure and reset behaviour.
module tb_seg_scan_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] seg_in;
    logic [1:0] dig_en;
    logic [7:0] dout;
    logic [1:0] dp_out;
    logic       out_valid;
    logic       out_ready;
    logic       err;
    logic [0:0] err_digit;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic [9:0]  acc_q[$];
    int unsigned vld_rise  = 0;
    int unsigned err_cnt   = 0;
    int unsigned err_wide  = 0;
    logic        vld_d     = 1'b0;
    logic        err_d     = 1'b0;
    logic [0:0]  err_last  = '0;

    seg_scan_decoder #(
        .NUM_DIGITS (2),
        .SETTLE_CYC (4),
        .STABLE_CNT (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_in    (seg_in),
        .dig_en    (dig_en),
        .dout      (dout),
        .dp_out    (dp_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err),
        .err_digit (err_digit)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_valid && out_ready) acc_q.push_back({dp_out, dout});
        if (out_valid && !vld_d) vld_rise <= vld_rise + 1;
        if (err) begin
            err_cnt  <= err_cnt + 1;
            err_last <= err_digit;
        end
        if (err && err_d) err_wide <= err_wide + 1;
        vld_d <= out_valid;
        err_d <= err;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic visit(input logic [1:0] en, input logic [7:0] code);
        dig_en = en;
        seg_in = code;
        tick(8);
    endtask

    task automatic round(input logic [7:0] c0, input logic [7:0] c1);
        visit(2'b01, c0);
        visit(2'b10, c1);
    endtask

    task automatic flush();
        dig_en = 2'b00;
        seg_in = 8'hFF;
        tick(6);
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        dig_en = 2'b00;
        seg_in = 8'hFF;
        tick(2);
        rst_n = 1'b1;
        tick(2);
    endtask

    function automatic logic [31:0] acc_at(input int unsigned idx);
        if (idx < acc_q.size()) return {22'd0, acc_q[idx]};
        return 32'hDEAD;
    endfunction

    int unsigned acc_base, rise_base, err_base;

    initial begin
        out_ready = 1'b1;
        do_reset();

        // reset state
        check("rst_dout", {24'd0, dout}, 32'h0);
        check("rst_dp", {30'd0, dp_out}, 32'h0);
        check("rst_valid", {31'd0, out_valid}, 32'h0);
        check("rst_err", {31'd0, err}, 32'h0);
        check("rst_err_digit", {31'd0, err_digit}, 32'h0);

        // basic "24": nothing after 2 visits, one frame after 3, none on repeats
        acc_base  = acc_q.size();
        rise_base = vld_rise;
        round(8'h99, 8'h25);
        round(8'h99, 8'h25);
        check("basic_early", acc_q.size() - acc_base, 0);
        round(8'h99, 8'h25);
        flush();
        check("basic_n", acc_q.size() - acc_base, 1);
        check("basic_frame", acc_at(acc_base), 32'h024);
        check("basic_valid_low", {31'd0, out_valid}, 32'h0);
        round(8'h99, 8'h25);
        round(8'h99, 8'h25);
        flush();
        check("basic_repeat_n", acc_q.size() - acc_base, 1);
        check("basic_rise", vld_rise - rise_base, 1);

        // decimal point on digit 0
        do_reset();
        acc_base = acc_q.size();
        repeat (3) round(8'h98, 8'h25);
        flush();
        check("dp_n", acc_q.size() - acc_base, 1);
        check("dp_frame", acc_at(acc_base), 32'h124);

        // blank digit blocks publishing, then "A4"
        do_reset();
        acc_base  = acc_q.size();
        rise_base = vld_rise;
        repeat (3) round(8'h99, 8'hFF);
        flush();
        check("blank_n", acc_q.size() - acc_base, 0);
        check("blank_rise", vld_rise - rise_base, 0);
        repeat (3) round(8'h99, 8'h11);
        flush();
        check("a4_n", acc_q.size() - acc_base, 1);
        check("a4_frame", acc_at(acc_base), 32'h0A4);

        // invalid patterns: err pulses with digit index, debounce restarts
        do_reset();
        acc_base = acc_q.size();
        err_base = err_cnt;
        repeat (3) round(8'h99, 8'h25);
        flush();
        check("err_pre_n", acc_q.size() - acc_base, 1);
        round(8'h99, 8'hFD);
        flush();
        check("err1_cnt", err_cnt - err_base, 1);
        check("err1_digit", {31'd0, err_last}, 32'h1);
        round(8'hFD, 8'h25);
        flush();
        check("err0_cnt", err_cnt - err_base, 2);
        check("err0_digit", {31'd0, err_last}, 32'h0);
        check("err_width", err_wide, 0);
        round(8'h49, 8'h25);
        round(8'h49, 8'h25);
        flush();
        check("err_recommit_early", acc_q.size() - acc_base, 1);
        round(8'h49, 8'h25);
        flush();
        check("err_recommit_n", acc_q.size() - acc_base, 2);
        check("err_recommit_frame", acc_at(acc_base + 1), 32'h025);

        // backpressure: 24 held, 37 overwritten in shadow by 15
        do_reset();
        out_ready = 1'b0;
        acc_base  = acc_q.size();
        repeat (3) round(8'h99, 8'h25);
        flush();
        check("bp_valid", {31'd0, out_valid}, 32'h1);
        check("bp_dout", {24'd0, dout}, 32'h24);
        repeat (3) round(8'h1F, 8'h0D);
        repeat (3) round(8'h49, 8'h9F);
        flush();
        check("bp_hold_valid", {31'd0, out_valid}, 32'h1);
        check("bp_hold_dout", {24'd0, dout}, 32'h24);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_first", {23'd0, out_valid, dout}, 32'h124);
        @(negedge clk);
        check("bp_gap", {31'd0, out_valid}, 32'h0);
        @(negedge clk);
        check("bp_second", {23'd0, out_valid, dout}, 32'h115);
        tick(4);
        check("bp_n", acc_q.size() - acc_base, 2);
        check("bp_acc0", acc_at(acc_base), 32'h024);
        check("bp_acc1", acc_at(acc_base + 1), 32'h015);

        // asynchronous reset in mid-SETTLE
        do_reset();
        out_ready = 1'b0;
        repeat (3) round(8'h99, 8'h25);
        flush();
        check("mr_pre_valid", {31'd0, out_valid}, 32'h1);
        dig_en = 2'b01;
        seg_in = 8'h99;
        tick(6);
        rst_n = 1'b0;
        #1;
        check("mr_dout", {24'd0, dout}, 32'h0);
        check("mr_valid", {31'd0, out_valid}, 32'h0);
        check("mr_dp", {30'd0, dp_out}, 32'h0);
        tick(1);
        dig_en = 2'b00;
        tick(2);
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick(2);
        acc_base  = acc_q.size();
        rise_base = vld_rise;
        round(8'h99, 8'h25);
        round(8'h99, 8'h25);
        flush();
        check("mr_no_partial", vld_rise - rise_base, 0);
        round(8'h99, 8'h25);
        flush();
        check("mr_after_n", acc_q.size() - acc_base, 1);
        check("mr_after_frame", acc_at(acc_base), 32'h024);

        // short visits and non-one-hot enables never sample
        do_reset();
        acc_base  = acc_q.size();
        rise_base = vld_rise;
        err_base  = err_cnt;
        for (int i = 0; i < 20; i++) begin
            dig_en = (i % 2 == 0) ? 2'b01 : 2'b10;
            seg_in = (i % 2 == 0) ? 8'hFD : 8'h25;
            tick(3);
        end
        dig_en = 2'b11;
        seg_in = 8'hFD;
        tick(20);
        flush();
        check("short_rise", vld_rise - rise_base, 0);
        check("short_acc", acc_q.size() - acc_base, 0);
        check("short_err", err_cnt - err_base, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
